mem_alu_sequencer: RTL and testbench

Command-driven sequencer that sits upstream of the 8-bit ALU and the 16×16 data memory, replacing hand-sequenced load/operate/store traffic. It accepts one command at a time: two source addresses, a destination address and an opcode. It reads both operands from memory over the single memory port, presents them to the ALU, writes the zero-extended result back, then reports completion.

---
 rtl/mem_alu_seq_pkg.sv | 30 +++
 rtl/mem_alu_sequencer.sv | 125 ++++++++++++
 tb/tb_mem_alu_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_alu_seq_pkg.sv
// Shared types for mem_alu_sequencer: FSM states, ALU opcodes, default widths.
// Opcode values are shared with the ALU and the benches.
package mem_alu_seq_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_A   = 3'd1,
    RD_B   = 3'd2,
    CAPT_B = 3'd3,
    WRITE  = 3'd4
  } state_t;

  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/mem_alu_sequencer.sv
// Reads two operands over one memory port, runs the ALU, writes back; done 5 cycles after accept
// (4 for unary ops with MEM_ALU_SEQ_UNARY_SKIP_EN). One command in flight; cmd_ready only in IDLE.
module mem_alu_sequencer
  import mem_alu_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        alu_opcode,
  output logic [OP_W-1:0]   alu_operand1,
  output logic [OP_W-1:0]   alu_operand2,
  input  logic [OP_W-1:0]   alu_result,
  output logic              busy,
  output logic              done,
  output logic [OP_W-1:0]   result,
  output logic              zero
);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
  } cmd_t;

  state_t            state, state_nxt;
  cmd_t              cmd_q;
  logic [OP_W-1:0]   op_a, op_b;
  logic [OP_W-1:0]   rdata_lo;
  logic [DATA_W-OP_W-1:0] rdata_hi_unused;

  assign rdata_lo        = mem_rdata[OP_W-1:0];
  assign rdata_hi_unused = mem_rdata[DATA_W-1:OP_W];

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign alu_opcode   = cmd_q.opcode;
  assign alu_operand1 = op_a;
  assign alu_operand2 = op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cmd_q  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q.opcode <= cmd_opcode;
            cmd_q.src_a  <= cmd_src_a;
            cmd_q.src_b  <= cmd_src_b;
            cmd_q.dst    <= cmd_dst;
          end
        end
        RD_B: begin
          // Read data for src_a lands here, one cycle after its address
          op_a <= rdata_lo;
`ifdef MEM_ALU_SEQ_UNARY_SKIP_EN
          if (is_unary(cmd_q.opcode)) op_b <= '0;
`endif
        end
        CAPT_B: op_b <= rdata_lo;
        WRITE: begin
          result <= alu_result;
          zero   <= (alu_result == '0);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: if (cmd_valid) state_nxt = RD_A;
      RD_A: begin
        mem_addr  = cmd_q.src_a;
        state_nxt = RD_B;
      end
      RD_B: begin
        mem_addr  = cmd_q.src_b;
        state_nxt = CAPT_B;
`ifdef MEM_ALU_SEQ_UNARY_SKIP_EN
        if (is_unary(cmd_q.opcode)) state_nxt = WRITE;
`endif
      end
      CAPT_B: begin
        mem_addr  = cmd_q.src_b;
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr  = cmd_q.dst;
        mem_we    = 1'b1;
        mem_wdata = {{(DATA_W-OP_W){1'b0}}, alu_result};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_alu_sequencer.sv
// Scoreboard bench for mem_alu_sequencer with a registered-read memory model and an ALU model.
// Honours MEM_ALU_SEQ_UNARY_SKIP_EN for expected latencies.
module tb_mem_alu_sequencer;
  import mem_alu_seq_pkg::*;

`ifdef MEM_ALU_SEQ_UNARY_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [3:0]  cmd_src_a, cmd_src_b, cmd_dst;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_operand1, alu_operand2, alu_result;
  logic        busy, done, zero;
  logic [7:0]  result;

  mem_alu_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (SKIP && (op == OP_NOT || op == OP_SHL || op == OP_SHR)) ? 4 : 5;
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_operand1, alu_operand2);

  // Memory model: one port, registered read; bench preloads through a side port while idle
  logic [15:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  res;
    int          wcyc;
    int          dcyc;
  } exp_t;

  exp_t        wq[$];
  exp_t        dq[$];
  logic [15:0] ref_mem [16];
  int          acc_cyc = -1;
  int          acc_lat = 0;
  logic [3:0]  saved_dst;
  logic [15:0] saved_old;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle outside reset, compare strobes and pop the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      bit   exp_busy, exp_we, exp_done;
      exp_busy = (acc_cyc >= 0) && (cyc > acc_cyc) && (cyc < acc_cyc + acc_lat);
      check("busy", busy, exp_busy);
      check("cmd_ready", cmd_ready, !exp_busy);
      exp_we = (wq.size() > 0) && (wq[0].wcyc == cyc);
      check("mem_we", mem_we, exp_we);
      if (exp_we) begin
        e = wq.pop_front();
        if (mem_we) begin
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.wdata);
        end
      end
      exp_done = (dq.size() > 0) && (dq[0].dcyc == cyc);
      check("done", done, exp_done);
      if (exp_done) begin
        e = dq.pop_front();
        if (done) begin
          check("result", result, e.res);
          check("zero", zero, e.res == 8'h00);
        end
      end
    end
  end

  // Reference: operands taken from the model memory at acceptance; both reads precede the write
  task automatic push_exp();
    exp_t       e;
    logic [7:0] a, b, r;
    int         l;
    l = lat_of(cmd_opcode);
    a = ref_mem[cmd_src_a][7:0];
    b = (l == 4) ? 8'h00 : ref_mem[cmd_src_b][7:0];
    r = alu_f(cmd_opcode, a, b);
    e.addr  = cmd_dst;
    e.wdata = {8'h00, r};
    e.res   = r;
    e.wcyc  = cyc + l - 1;
    e.dcyc  = cyc + l;
    wq.push_back(e);
    dq.push_back(e);
    saved_dst = cmd_dst;
    saved_old = ref_mem[cmd_dst];
    ref_mem[cmd_dst] = {8'h00, r};
    acc_cyc = cyc;
    acc_lat = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    bit got = 1'b0;
    cmd_opcode = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmd_ready) begin
        push_exp();
        got = 1'b1;
      end
      step();
    end
    check("accept_timeout", got, 1'b1);
    cmd_valid  = 1'b0;
    cmd_opcode = 3'($urandom); cmd_src_a = 4'($urandom);
    cmd_src_b  = 4'($urandom); cmd_dst   = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && (dq.size() != 0 || busy); i++) step();
    check("idle_timeout", dq.size(), 0);
    step();
  endtask

  initial begin
    int prev_acc, prev_lat;
    rst = 1'b1; cmd_valid = 1'b1;
    cmd_opcode = OP_SUB; cmd_src_a = 4'd1; cmd_src_b = 4'd2; cmd_dst = 4'd3;
    repeat (3) step();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_zero", zero, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 4'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_alu_opcode", alu_opcode, 3'h0);
    check("rst_op_a", alu_operand1, 8'h00);
    check("rst_op_b", alu_operand2, 8'h00);
    step();
    rst = 1'b0; cmd_valid = 1'b0;

    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));

    // Directed cases
    preload(4'd0, 16'h0010); preload(4'd1, 16'h0020);
    run_cmd(OP_ADD, 4'd0, 4'd1, 4'd3); wait_idle();
    check("add_result", result, 8'h30);
    check("add_mem3", mem[3], 16'h0030);
    preload(4'd2, 16'h0030);
    run_cmd(OP_SUB, 4'd3, 4'd2, 4'd3); wait_idle();
    check("sub_zero", zero, 1'b1);
    check("sub_mem3", mem[3], 16'h0000);
    preload(4'd5, 16'hAB01); preload(4'd6, 16'h00FF);
    run_cmd(OP_ADD, 4'd5, 4'd6, 4'd7); wait_idle();
    check("upper_zero", zero, 1'b1);
    check("upper_mem7", mem[7], 16'h0000);
    run_cmd(OP_NOT, 4'd0, 4'd9, 4'd8); wait_idle();
    check("not_mem8", mem[8], 16'h00EF);

    // Reset while in RD_B: command dropped, memory untouched
    run_cmd(OP_ADD, 4'd0, 4'd1, 4'd9);
    step();
    rst = 1'b1;
    wq.delete(); dq.delete();
    acc_cyc = -1; acc_lat = 0;
    ref_mem[saved_dst] = saved_old;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", result, 8'h00);
    check("midrst_zero", zero, 1'b0);
    repeat (6) step();
    check("midrst_mem9", mem[9], ref_mem[9]);

    // Valid held high with changing fields: accept only in IDLE / done cycles
    prev_acc = -1; prev_lat = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cmd_opcode = 3'($urandom); cmd_src_a = 4'($urandom);
      cmd_src_b  = 4'($urandom); cmd_dst   = 4'($urandom);
      if (cmd_ready) begin
        if (prev_acc >= 0) check("b2b_gap", cyc - prev_acc, prev_lat);
        prev_acc = cyc;
        prev_lat = lat_of(cmd_opcode);
        push_exp();
      end
      step();
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Random commands with random idle gaps
    for (int i = 0; i < 40; i++) begin
      run_cmd(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 6)) step();
    end
    wait_idle();

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);
    check("wq_empty", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
